// File: rtl/console_pkg.sv
// Shared types and constants for the console write-side controller.
package console_pkg;

  typedef enum logic [1:0] {
    StClearScreen,
    StIdle,
    StWrite,
    StClearLine
  } state_e;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 24;

endpackage

// File: rtl/console_writer_if.sv
// Byte-stream input handshake plus character buffer write port.
interface console_writer_if #(
  parameter int unsigned ADDR_W = 11
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_din;
  logic              buf_wen;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  buf_addr,
    input  buf_din,
    input  buf_wen
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output buf_addr,
    output buf_din,
    output buf_wen
  );

endinterface

// File: rtl/console_fill.sv
// Fill sequencer: while run is high, emits len consecutive addresses from base, then done.
module console_fill #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              px_clk,
  input  logic              clr,
  input  logic              run,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic              wen,
  output logic              done
);

  logic [ADDR_W:0] cnt_q, cnt_d;

  assign wen  = run && (cnt_q < len);
  assign done = run && (cnt_q == len);
  assign addr = base + cnt_q[ADDR_W-1:0];

  // Counter parks at len until run drops, so done holds for the caller to sample.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (wen) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/console_writer.sv
// Write-side controller for the text buffer: control codes, cursor, hardware scroll and clears.
module console_writer
  import console_pkg::*;
#(
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned ADDR_W    = 11,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic             px_clk,
  input  logic             clr,
  console_writer_if.slave  bus,
  output logic [6:0]       cursor_col,
  output logic [4:0]       cursor_row,
  output logic [4:0]       scroll_row,
  output logic             busy
);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   len_t;

  localparam logic [6:0] LastCol   = 7'(COLS - 1);
  localparam logic [4:0] LastRow   = 5'(ROWS - 1);
  localparam logic [5:0] Rows6     = 6'(ROWS);
  localparam len_t       ScreenLen = len_t'(COLS * ROWS);
  localparam len_t       LineLen   = len_t'(COLS);

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  scroll_q, scroll_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        wen_q, wen_d;
  addr_t       addr_q, addr_d;
  logic [7:0]  din_q, din_d;

  logic        accept, printable, newline;
  logic [5:0]  phys_sum;
  logic [4:0]  phys_line;
  addr_t       line_base, cur_addr;
  logic        fill_run, fill_wen, fill_done;
  addr_t       fill_base, fill_addr;
  len_t        fill_len;

  assign accept    = bus.in_valid && ready_q;
  assign printable = (bus.in_data >= PRINT_LO) && (bus.in_data <= PRINT_HI);

  assign phys_sum  = {1'b0, scroll_q} + {1'b0, row_q};
  assign phys_line = (phys_sum >= Rows6) ? 5'(phys_sum - Rows6) : phys_sum[4:0];
  assign line_base = addr_t'({phys_line, 6'b0}) + addr_t'({phys_line, 4'b0});
  assign cur_addr  = line_base + addr_t'(col_q);

  // In CLEAR_LINE the row is pinned at the bottom, so line_base is the new bottom line.
  assign fill_run  = (state_q == StClearScreen) || (state_q == StClearLine);
  assign fill_base = (state_q == StClearLine) ? line_base : '0;
  assign fill_len  = (state_q == StClearLine) ? LineLen : ScreenLen;

  console_fill #(
    .ADDR_W(ADDR_W)
  ) u_fill (
    .px_clk(px_clk),
    .clr   (clr),
    .run   (fill_run),
    .base  (fill_base),
    .len   (fill_len),
    .addr  (fill_addr),
    .wen   (fill_wen),
    .done  (fill_done)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    scroll_d = scroll_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wen_d    = 1'b0;
    newline  = 1'b0;

    if (fill_wen) begin
      wen_d  = 1'b1;
      addr_d = fill_addr;
      din_d  = FILL_CHAR;
    end

    unique case (state_q)
      StClearScreen: begin
        if (fill_done) begin
          state_d  = StIdle;
          col_d    = '0;
          row_d    = '0;
          scroll_d = '0;
        end
      end
      StIdle: begin
        if (accept) begin
          if (printable) begin
            wen_d   = 1'b1;
            addr_d  = cur_addr;
            din_d   = bus.in_data;
            state_d = StWrite;
          end else begin
            case (bus.in_data)
              CC_CR: col_d = '0;
              CC_LF: newline = 1'b1;
              CC_BS: if (col_q != '0) col_d = col_q - 1'b1;
              CC_FF: state_d = StClearScreen;
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        if (col_q == LastCol) begin
          col_d   = '0;
          newline = 1'b1;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = StIdle;
        end
      end
      StClearLine: begin
        if (fill_done) state_d = StIdle;
      end
      default: state_d = StClearScreen;
    endcase

    if (newline) begin
      if (row_q < LastRow) begin
        row_d   = row_q + 1'b1;
        state_d = StIdle;
      end else begin
        scroll_d = (scroll_q == LastRow) ? '0 : scroll_q + 1'b1;
        state_d  = StClearLine;
      end
    end

    ready_d = (state_d == StIdle);
    busy_d  = (state_d == StClearScreen) || (state_d == StClearLine);
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state_q  <= StClearScreen;
      col_q    <= '0;
      row_q    <= '0;
      scroll_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      scroll_q <= scroll_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.buf_wen  = wen_q;
  assign bus.buf_addr = addr_q;
  assign bus.buf_din  = din_q;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;
  assign scroll_row   = scroll_q;
  assign busy         = busy_q;

endmodule
